// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero, optional write-to-read bypass and a busy scoreboard.
// Reads are combinational, the debug port has 1-cycle latency, and there is no backpressure (every port is accepted each cycle).
module regfile_mp #(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int REG_BITS  = $clog2(REG_COUNT),
  parameter int NR        = 2,
  parameter int NW        = 1,
  parameter int BYPASS    = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NR*REG_BITS-1:0] rd_addr,
  output logic [NR*WIDTH-1:0]    rd_data,
  output logic [NR-1:0]          rd_busy,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW*REG_BITS-1:0] wr_addr,
  input  logic [NW*WIDTH-1:0]    wr_data,
  input  logic                   iss_en,
  input  logic [REG_BITS-1:0]    iss_addr,
  input  logic [REG_BITS-1:0]    dbg_addr,
  output logic [WIDTH-1:0]       dbg_data,
  output logic [REG_COUNT-1:0]   busy_vec
);

  logic [WIDTH-1:0]     regs_q [REG_COUNT];
  logic [WIDTH-1:0]     regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;
  logic [WIDTH-1:0]     dbg_q;
  logic [WIDTH-1:0]     dbg_d;

  // Ports are walked in ascending order so the highest-numbered port wins a
  // same-address conflict; the issue set is applied last so a new producer wins.
  always_comb begin
    logic [REG_BITS-1:0] wa;
    wa = '0;
    for (int n = 0; n < REG_COUNT; n++) begin
      regs_d[n] = regs_q[n];
    end
    busy_d = busy_q;
    for (int w = 0; w < NW; w++) begin
      wa = wr_addr[w*REG_BITS +: REG_BITS];
      if (wr_en[w] && (wa != '0)) begin
        regs_d[wa] = wr_data[w*WIDTH +: WIDTH];
        busy_d[wa] = 1'b0;
      end
    end
    if (iss_en && (iss_addr != '0)) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
    dbg_d     = regs_q[dbg_addr];
  end

  always_comb begin
    logic [REG_BITS-1:0] ra;
    logic [WIDTH-1:0]    val;
    logic                hit;
    ra      = '0;
    val     = '0;
    hit     = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NR; i++) begin
      ra  = rd_addr[i*REG_BITS +: REG_BITS];
      val = regs_q[ra];
      hit = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NW; w++) begin
          if (wr_en[w] && (wr_addr[w*REG_BITS +: REG_BITS] == ra) && (ra != '0)) begin
            val = wr_data[w*WIDTH +: WIDTH];
            hit = 1'b1;
          end
        end
      end
      if (ra == '0) begin
        val = '0;
      end
      rd_data[i*WIDTH +: WIDTH] = val;
      rd_busy[i]                = busy_q[ra] & ~hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < REG_COUNT; n++) begin
        regs_q[n] <= '0;
      end
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      for (int n = 0; n < REG_COUNT; n++) begin
        regs_q[n] <= regs_d[n];
      end
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboarded bench: two regfile_mp instances (BYPASS=0 and BYPASS=1) share stimulus;
// a reference model predicts every cycle's outputs and a monitor compares them at negedge.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int RB = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic             clk;
  logic             rstn;
  logic [NR*RB-1:0] rd_addr;
  logic [NW-1:0]    wr_en;
  logic [NW*RB-1:0] wr_addr;
  logic [NW*W-1:0]  wr_data;
  logic             iss_en;
  logic [RB-1:0]    iss_addr;
  logic [RB-1:0]    dbg_addr;

  logic [NR*W-1:0]  rd_data0, rd_data1;
  logic [NR-1:0]    rd_busy0, rd_busy1;
  logic [W-1:0]     dbg_data0, dbg_data1;
  logic [31:0]      busy_vec0, busy_vec1;

  regfile_mp #(.WIDTH(W), .REG_COUNT(32), .NR(NR), .NW(NW), .BYPASS(0)) dut0 (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data0), .busy_vec(busy_vec0)
  );

  regfile_mp #(.WIDTH(W), .REG_COUNT(32), .NR(NR), .NW(NW), .BYPASS(1)) dut1 (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_data1), .busy_vec(busy_vec1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [NR*W-1:0] rd0;
    logic [NR-1:0]   rb0;
    logic [NR*W-1:0] rd1;
    logic [NR-1:0]   rb1;
    logic [31:0]     bv;
    logic [W-1:0]    dbg;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference architectural state
  logic [W-1:0] mem [32];
  logic         busy [32];
  logic [W-1:0] dbg_m;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 32; n++) begin
      mem[n]  = '0;
      busy[n] = 1'b0;
    end
    dbg_m = '0;
  endtask

  function automatic logic [31:0] busy_word();
    logic [31:0] b;
    for (int n = 0; n < 32; n++) b[n] = busy[n];
    return b;
  endfunction

  task automatic drive(input logic [RB-1:0] r0, input logic [RB-1:0] r1, input logic [RB-1:0] r2,
                       input logic [1:0] we, input logic [RB-1:0] a0, input logic [W-1:0] d0,
                       input logic [RB-1:0] a1, input logic [W-1:0] d1,
                       input logic ie, input logic [RB-1:0] ia, input logic [RB-1:0] da);
    rd_addr  = {r2, r1, r0};
    wr_en    = we;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    iss_en   = ie;
    iss_addr = ia;
    dbg_addr = da;
  endtask

  // Predict this cycle's outputs, push them, then advance the model across the edge.
  task automatic step();
    exp_t        e;
    logic [RB-1:0] a;
    logic [W-1:0]  v;
    logic          hit;
    logic [W-1:0]  nd;
    #1;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*RB +: RB];
      v = (a == 0) ? '0 : mem[a];
      e.rd0[i*W +: W] = v;
      e.rb0[i]        = busy[a];
      hit = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && wr_addr[w*RB +: RB] == a && a != 0) begin
          v   = wr_data[w*W +: W];
          hit = 1'b1;
        end
      end
      e.rd1[i*W +: W] = v;
      e.rb1[i]        = busy[a] && !hit;
    end
    e.bv  = busy_word();
    e.dbg = dbg_m;
    q.push_back(e);
    @(posedge clk);
    nd = mem[dbg_addr];
    for (int w = 0; w < NW; w++) begin
      a = wr_addr[w*RB +: RB];
      if (wr_en[w] && a != 0) begin
        mem[a]  = wr_data[w*W +: W];
        busy[a] = 1'b0;
      end
    end
    if (iss_en && iss_addr != 0) busy[iss_addr] = 1'b1;
    dbg_m = nd;
    #2;
  endtask

  task automatic idle(input logic [RB-1:0] r0, input logic [RB-1:0] r1, input logic [RB-1:0] da);
    drive(r0, r1, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, da);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rd_data_nobyp", rd_data0, e.rd0);
      chk("rd_busy_nobyp", rd_busy0, e.rb0);
      chk("rd_data_byp",   rd_data1, e.rd1);
      chk("rd_busy_byp",   rd_busy1, e.rb1);
      chk("busy_vec_nobyp", busy_vec0, e.bv);
      chk("busy_vec_byp",   busy_vec1, e.bv);
      chk("dbg_nobyp", dbg_data0, e.dbg);
      chk("dbg_byp",   dbg_data1, e.dbg);
    end
  end

  function automatic logic [RB-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return RB'($urandom_range(0, 31));
    return RB'($urandom_range(0, 7));
  endfunction

  initial begin
    int guard;
    rstn = 1'b0;
    idle(5'd5, 5'd0, 5'd5);
    model_clear();
    #3;
    chk("reset_rd", rd_data0, 96'd0);
    chk("reset_busy", busy_vec1, 32'd0);
    chk("reset_dbg", dbg_data1, 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #2;

    // x5 = DEADBEEF, then reset mid-run
    drive(5'd5, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    step();
    idle(5'd5, 5'd0, 5'd5);
    step();
    idle(5'd5, 5'd0, 5'd5);
    #1;
    chk("x5_before_reset", rd_data0[31:0], 32'hDEADBEEF);
    rstn = 1'b0;
    model_clear();
    #1;
    chk("x5_after_reset", rd_data0[31:0], 32'd0);
    chk("busy_after_reset", busy_vec0, 32'd0);
    chk("dbg_after_reset", dbg_data0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk);
    #2;

    // Write to x0 is discarded, bypassed or not
    drive(5'd0, 5'd0, 5'd0, 2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("x0_bypass", rd_data1[31:0], 32'd0);
    step();
    idle(5'd0, 5'd0, 5'd0);
    #1;
    chk("x0_stored", rd_data0[31:0], 32'd0);
    step();

    // Basic write/read and debug latency
    drive(5'd11, 5'd0, 5'd0, 2'b01, 5'd11, 32'hA5A5A5A5, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11);
    #1;
    chk("x11_same_cycle_nobyp", rd_data0[31:0], 32'd0);
    step();
    idle(5'd11, 5'd0, 5'd11);
    #1;
    chk("x11_next_cycle", rd_data0[31:0], 32'hA5A5A5A5);
    chk("dbg_x11_not_yet", dbg_data0, 32'd0);
    step();
    idle(5'd11, 5'd0, 5'd11);
    #1;
    chk("dbg_x11", dbg_data0, 32'hA5A5A5A5);
    step();

    // Bypass to x6, and bypass of a write to x0
    drive(5'd6, 5'd0, 5'd0, 2'b11, 5'd6, 32'h55, 5'd0, 32'h77, 1'b0, 5'd0, 5'd0);
    #1;
    chk("bypass_x6", rd_data1[31:0], 32'h55);
    chk("bypass_x0", rd_data1[63:32], 32'd0);
    step();

    // Same-address conflict: port1 wins
    drive(5'd0, 5'd7, 5'd0, 2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7);
    #1;
    chk("conflict_bypass", rd_data1[63:32], 32'h2);
    step();
    idle(5'd0, 5'd7, 5'd7);
    #1;
    chk("conflict_stored", rd_data0[63:32], 32'h2);
    step();

    // Scoreboard
    drive(5'd9, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0);
    step();
    idle(5'd9, 5'd0, 5'd0);
    #1;
    chk("iss_busy_vec", busy_vec1[9], 1'b1);
    chk("iss_rd_busy", rd_busy1[0], 1'b1);
    step();
    drive(5'd9, 5'd0, 5'd0, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    #1;
    chk("wr_masks_busy_byp", rd_busy1[0], 1'b0);
    chk("wr_raw_busy_nobyp", rd_busy0[0], 1'b1);
    step();
    idle(5'd9, 5'd0, 5'd0);
    #1;
    chk("wr_clears_busy", busy_vec0[9], 1'b0);
    step();
    drive(5'd9, 5'd0, 5'd0, 2'b01, 5'd9, 32'h98, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0);
    step();
    drive(5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    #1;
    chk("set_beats_clear", busy_vec0[9], 1'b1);
    step();
    idle(5'd0, 5'd0, 5'd0);
    #1;
    chk("iss_x0_noop", busy_vec0, 32'h0000_0200);
    chk("rd_busy_x0", rd_busy0[0], 1'b0);
    step();

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      drive(rnd_addr(), rnd_addr(), rnd_addr(), 2'($urandom_range(0, 3)),
            rnd_addr(), $urandom(), rnd_addr(), $urandom(),
            1'($urandom_range(0, 1)), rnd_addr(), rnd_addr());
      step();
    end

    idle(5'd0, 5'd0, 5'd0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain act=%0d exp=0 pending entries", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
